regfile_access_port: RTL

REGFILE_ACCESS_PORT -- requirements
Module: regfile_access_port

---
 rtl/regfile_access_port_if.sv | 25 ++
 rtl/regfile_access_port.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile_access_port_if.sv
// Command/response bus between a requester and regfile_access_port.
// master = requester side, slave = access-port side.
interface regfile_access_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_dump;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_last;

    modport master (
        output req_valid, req_write, req_dump, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_dump, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
    );
endinterface

// File: rtl/regfile_access_port.sv
// Single-port command front end for a 32x32 register file: write-then-verify
// writes, single reads and a full 32-register dump streamed as response beats.
module regfile_access_port (
    input  logic                        clk,
    input  logic                        rst_n,
    regfile_access_port_if.slave        bus,
    output logic [4:0]                  rf_rd_address,
    input  logic [31:0]                 rf_data,
    output logic                        rf_wr_enable,
    output logic [4:0]                  rf_wr_address,
    output logic [31:0]                 rf_wr_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        w_rsp_fire;

    logic        r_dump;
    logic [4:0]  r_idx;
    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_rsp_valid;
    logic [4:0]  r_rsp_addr;
    logic [31:0] r_rsp_data;
    logic        r_rsp_last;

    // Next-state decode and handshake qualification.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rsp_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (bus.req_write && !bus.req_dump) ? S_WRITE : S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITE: w_next_state = S_READ;
            S_READ:  w_next_state = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_fire   = 1'b1;
                    w_next_state = r_rsp_last ? S_IDLE : S_READ;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command latch and read index; the index doubles as the dump counter and
    // saturates at 31 because the last beat never increments it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dump <= 1'b0;
            r_idx  <= 5'd0;
        end else if (w_accept) begin
            r_dump <= bus.req_dump;
            r_idx  <= bus.req_dump ? 5'd0 : bus.req_addr;
        end else if (w_rsp_fire && !r_rsp_last) begin
            r_idx  <= r_idx + 5'd1;
        end
    end

    // Write port: one-cycle enable, address/data hold their last latched value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_data <= 32'd0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept && bus.req_write && !bus.req_dump) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= bus.req_addr;
                r_wr_data <= bus.req_wdata;
            end
        end
    end

    // Response beat: captured at the end of READ, held until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= 5'd0;
            r_rsp_data  <= 32'd0;
            r_rsp_last  <= 1'b0;
        end else if (r_state == S_READ) begin
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= r_idx;
            r_rsp_data  <= rf_data;
            r_rsp_last  <= !r_dump || (r_idx == 5'd31);
        end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_addr   = r_rsp_addr;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_last   = r_rsp_last;
    assign rf_rd_address  = r_idx;
    assign rf_wr_enable   = r_wr_en;
    assign rf_wr_address  = r_wr_addr;
    assign rf_wr_data     = r_wr_data;

endmodule
